// File: rtl/spectrum_wr_sched_if.sv
// FFT magnitude stream in, spectrum FIFO write port out. The scheduler is the
// master of the FIFO write side; the FFT/FIFO environment uses the slave view.
interface spectrum_wr_sched_if #(
  parameter int DATA_W = 16,
  parameter int USED_W = 8
);
  logic [DATA_W-1:0] fft_data;
  logic              fft_sop;
  logic              fft_eop;
  logic              fft_valid;
  logic [USED_W-1:0] fifo_wrusedw;
  logic              fifo_full;
  logic              fifo_wr_req;
  logic [DATA_W-1:0] fifo_wr_data;

  modport master (
    input  fft_data, fft_sop, fft_eop, fft_valid, fifo_wrusedw, fifo_full,
    output fifo_wr_req, fifo_wr_data
  );

  modport slave (
    output fft_data, fft_sop, fft_eop, fft_valid, fifo_wrusedw, fifo_full,
    input  fifo_wr_req, fifo_wr_data
  );
endinterface

// File: rtl/spectrum_wr_sched.sv
// Frame-decimating write scheduler: admits whole FFT frames into the spectrum
// FIFO, scales/saturates bins into bar lengths and pads short frames with zeros.
module spectrum_wr_sched #(
  parameter int              DATA_W      = 16,
  parameter int              NUM_BINS    = 64,
  parameter int              DECIM       = 4,
  parameter int              FIFO_DEPTH  = 256,
  parameter int              SCALE_SHIFT = 3,
  parameter logic [DATA_W-1:0] MAX_LEVEL = 16'd400
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 enable,
  spectrum_wr_sched_if.master  bus,
  output logic                 frame_wr_done,
  output logic [15:0]          frames_written,
  output logic [15:0]          frames_dropped,
  output logic                 ovf_sticky,
  output logic                 err_sticky
);
  localparam int BIN_W   = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int DEC_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int USED_W  = $clog2(FIFO_DEPTH);
  localparam int LAST_I  = NUM_BINS - 1;
  localparam int DLAST_I = DECIM - 1;
  localparam int ROOM_I  = FIFO_DEPTH - NUM_BINS;
  localparam logic [BIN_W-1:0]  LAST_BIN = LAST_I[BIN_W-1:0];
  localparam logic [DEC_W-1:0]  DEC_LAST = DLAST_I[DEC_W-1:0];
  localparam logic [USED_W:0]   ROOM     = ROOM_I[USED_W:0];

  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, PAD, DRAIN, SKIP} state_t;

  function automatic logic [DATA_W-1:0] sat_scale(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] s;
    s = d >> SCALE_SHIFT;
    return (s > MAX_LEVEL) ? MAX_LEVEL : s;
  endfunction

  state_t            state;
  logic [BIN_W-1:0]  bin_cnt;
  logic [DEC_W-1:0]  decim_cnt;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1;

  logic              sop_beat;
  logic              eop_beat;
  logic              room;
  logic [DATA_W-1:0] scaled_p0;

  assign sop_beat  = bus.fft_valid & bus.fft_sop;
  assign eop_beat  = bus.fft_valid & bus.fft_eop;
  assign room      = ({1'b0, bus.fifo_wrusedw} <= ROOM);
  assign scaled_p0 = sat_scale(bus.fft_data);

  assign bus.fifo_wr_req  = vld_p1;
  assign bus.fifo_wr_data = data_p1;

  // p0 -> p1: accepted beat becomes a FIFO write; p1 -> p2: frame completion
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bin_cnt        <= '0;
      decim_cnt      <= '0;
      vld_p1         <= 1'b0;
      data_p1        <= '0;
      last_p1        <= 1'b0;
      frame_wr_done  <= 1'b0;
      frames_written <= '0;
      frames_dropped <= '0;
      ovf_sticky     <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      vld_p1        <= 1'b0;
      last_p1       <= 1'b0;
      frame_wr_done <= last_p1;
      if (last_p1) frames_written <= frames_written + 16'd1;
      if (vld_p1 && bus.fifo_full) ovf_sticky <= 1'b1;

      case (state)
        IDLE: if (enable) state <= ARM;

        ARM: begin
          if (!enable) begin
            state <= IDLE;
          end else if (sop_beat) begin
            decim_cnt <= (decim_cnt == DEC_LAST) ? '0 : decim_cnt + DEC_W'(1);
            if (decim_cnt == '0 && room) begin
              vld_p1  <= 1'b1;
              data_p1 <= scaled_p0;
              bin_cnt <= BIN_W'(1);
              state   <= bus.fft_eop ? PAD : CAPTURE;
            end else begin
              if (decim_cnt == '0) frames_dropped <= frames_dropped + 16'd1;
              if (!bus.fft_eop) state <= SKIP;
            end
          end
        end

        CAPTURE: begin
          if (sop_beat) begin
            // interrupting frame is abandoned; pad keeps the frame size fixed
            err_sticky <= 1'b1;
            state      <= PAD;
          end else if (bus.fft_valid) begin
            vld_p1  <= 1'b1;
            data_p1 <= scaled_p0;
            if (bin_cnt == LAST_BIN) begin
              last_p1 <= 1'b1;
              bin_cnt <= '0;
              state   <= bus.fft_eop ? ARM : DRAIN;
            end else begin
              bin_cnt <= bin_cnt + BIN_W'(1);
              if (bus.fft_eop) state <= PAD;
            end
          end
        end

        PAD: begin
          vld_p1  <= 1'b1;
          data_p1 <= '0;
          if (bin_cnt == LAST_BIN) begin
            last_p1 <= 1'b1;
            bin_cnt <= '0;
            state   <= ARM;
          end else begin
            bin_cnt <= bin_cnt + BIN_W'(1);
          end
        end

        DRAIN, SKIP: begin
          if (sop_beat) err_sticky <= 1'b1;
          if (eop_beat) state <= ARM;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spectrum_wr_sched.sv
// Directed bench: one scheduler with DECIM=1 and one with DECIM=4 share the stimulus.
module tb_spectrum_wr_sched;
  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] fft_data;
  logic        fft_sop, fft_eop, fft_valid;
  logic [7:0]  fifo_wrusedw;
  logic        fifo_full;

  logic        fd1, fd4, ovf1, ovf4, err1, err4;
  logic [15:0] fw1, fw4, fdr1, fdr4;

  int errors = 0;
  int checks = 0;
  logic [15:0] q1[$];
  logic [15:0] q4[$];
  int done1 = 0;
  int done4 = 0;
  logic [15:0] frame_dat [0:255];

  always #5 clk_50m = ~clk_50m;

  spectrum_wr_sched_if bus1 ();
  spectrum_wr_sched_if bus4 ();

  assign bus1.fft_data = fft_data;      assign bus4.fft_data = fft_data;
  assign bus1.fft_sop = fft_sop;        assign bus4.fft_sop = fft_sop;
  assign bus1.fft_eop = fft_eop;        assign bus4.fft_eop = fft_eop;
  assign bus1.fft_valid = fft_valid;    assign bus4.fft_valid = fft_valid;
  assign bus1.fifo_wrusedw = fifo_wrusedw; assign bus4.fifo_wrusedw = fifo_wrusedw;
  assign bus1.fifo_full = fifo_full;    assign bus4.fifo_full = fifo_full;

  spectrum_wr_sched #(.DECIM(1)) u_dut1 (
    .clk_50m(clk_50m), .rst_n(rst_n), .enable(enable), .bus(bus1.master),
    .frame_wr_done(fd1), .frames_written(fw1), .frames_dropped(fdr1),
    .ovf_sticky(ovf1), .err_sticky(err1)
  );

  spectrum_wr_sched #(.DECIM(4)) u_dut4 (
    .clk_50m(clk_50m), .rst_n(rst_n), .enable(enable), .bus(bus4.master),
    .frame_wr_done(fd4), .frames_written(fw4), .frames_dropped(fdr4),
    .ovf_sticky(ovf4), .err_sticky(err4)
  );

  always @(negedge clk_50m) begin
    if (bus1.fifo_wr_req === 1'b1) q1.push_back(bus1.fifo_wr_data);
    if (bus4.fifo_wr_req === 1'b1) q4.push_back(bus4.fifo_wr_data);
    if (fd1 === 1'b1) done1++;
    if (fd4 === 1'b1) done4++;
  end

  task automatic fill_ramp(input int base);
    for (int i = 0; i < 256; i++) frame_dat[i] = 16'((i + base) * 8);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50m);
      fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
    end
  endtask

  task automatic do_reset(input logic en);
    rst_n = 1'b0;
    fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0; fft_data = '0;
    fifo_wrusedw = '0; fifo_full = 1'b0; enable = en;
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50m);
    q1.delete(); q4.delete(); done1 = 0; done4 = 0;
  endtask

  task automatic send_frame(input int len, input int err_at, input int en_off_at);
    for (int i = 0; i < len; i++) begin
      @(negedge clk_50m);
      fft_valid = 1'b1;
      fft_sop   = (i == 0) || (i == err_at);
      fft_eop   = (i == len - 1);
      fft_data  = frame_dat[i];
      if (i == en_off_at) enable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1;
    fft_valid = 1'b1; fft_sop = 1'b1; fft_eop = 1'b0; fft_data = 16'h1234;
    fifo_wrusedw = '0; fifo_full = 1'b1;
    repeat (3) @(negedge clk_50m);
    checks++; if (bus1.fifo_wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %b want 0", bus1.fifo_wr_req); end
    checks++; if (bus1.fifo_wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data: got %0d want 0", bus1.fifo_wr_data); end
    checks++; if (fd1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", fd1); end
    checks++; if (fw1 !== 16'd0) begin errors++; $display("FAIL reset_written: got %0d want 0", fw1); end
    checks++; if (fdr1 !== 16'd0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", fdr1); end
    checks++; if ({ovf1, err1} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b want 00", {ovf1, err1}); end
    checks++; if ({bus4.fifo_wr_req, fd4, ovf4, err4} !== 4'b0000) begin errors++; $display("FAIL reset_dut4: got %b want 0000", {bus4.fifo_wr_req, fd4, ovf4, err4}); end
  endtask

  task automatic test_basic();
    do_reset(1'b1); fill_ramp(0);
    send_frame(128, -1, -1); idle(80);
    checks++; if (q1.size() !== 64) begin errors++; $display("FAIL basic_count: got %0d want 64", q1.size()); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (q1[i] !== 16'(i)) begin errors++; $display("FAIL basic_bin%0d: got %0d want %0d", i, q1[i], i); end
    end
    checks++; if (done1 !== 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done1); end
    checks++; if (fw1 !== 16'd1) begin errors++; $display("FAIL basic_written: got %0d want 1", fw1); end
    checks++; if ({ovf1, err1} !== 2'b00) begin errors++; $display("FAIL basic_sticky: got %b want 00", {ovf1, err1}); end
  endtask

  task automatic test_decim();
    do_reset(1'b1); fill_ramp(0);
    for (int f = 0; f < 8; f++) send_frame(128, -1, -1);
    idle(80);
    checks++; if (q4.size() !== 128) begin errors++; $display("FAIL decim_count: got %0d want 128", q4.size()); end
    checks++; if (fdr4 !== 16'd0) begin errors++; $display("FAIL decim_dropped: got %0d want 0", fdr4); end
    checks++; if (fw4 !== 16'd2) begin errors++; $display("FAIL decim_written: got %0d want 2", fw4); end
    checks++; if (done4 !== 2) begin errors++; $display("FAIL decim_done: got %0d want 2", done4); end
    checks++; if (q4[63] !== 16'd63) begin errors++; $display("FAIL decim_f0_last: got %0d want 63", q4[63]); end
    checks++; if (q4[64 + 17] !== 16'd17) begin errors++; $display("FAIL decim_f4_bin17: got %0d want 17", q4[64 + 17]); end
    checks++; if (q1.size() !== 512) begin errors++; $display("FAIL decim1_count: got %0d want 512", q1.size()); end
  endtask

  task automatic test_room();
    do_reset(1'b1); fill_ramp(0);
    fifo_wrusedw = 8'd193;
    send_frame(70, -1, -1); idle(80);
    checks++; if (q1.size() !== 0) begin errors++; $display("FAIL room_full_count: got %0d want 0", q1.size()); end
    checks++; if (fdr1 !== 16'd1) begin errors++; $display("FAIL room_dropped: got %0d want 1", fdr1); end
    checks++; if (fw1 !== 16'd0) begin errors++; $display("FAIL room_full_written: got %0d want 0", fw1); end
    fifo_wrusedw = 8'd192;
    send_frame(70, -1, -1); idle(80);
    checks++; if (q1.size() !== 64) begin errors++; $display("FAIL room_ok_count: got %0d want 64", q1.size()); end
    checks++; if (q1[63] !== 16'd63) begin errors++; $display("FAIL room_ok_last: got %0d want 63", q1[63]); end
    checks++; if ({fw1, fdr1} !== {16'd1, 16'd1}) begin errors++; $display("FAIL room_counts: got written=%0d dropped=%0d want 1 1", fw1, fdr1); end
    fifo_wrusedw = '0;
  endtask

  task automatic test_saturate();
    do_reset(1'b1); fill_ramp(0);
    frame_dat[0] = 16'hFFFF; frame_dat[1] = 16'd3199; frame_dat[2] = 16'd3200;
    frame_dat[3] = 16'd7;    frame_dat[4] = 16'd15;
    send_frame(64, -1, -1); idle(80);
    checks++; if (q1[0] !== 16'd400) begin errors++; $display("FAIL sat_ffff: got %0d want 400", q1[0]); end
    checks++; if (q1[1] !== 16'd399) begin errors++; $display("FAIL sat_3199: got %0d want 399", q1[1]); end
    checks++; if (q1[2] !== 16'd400) begin errors++; $display("FAIL sat_3200: got %0d want 400", q1[2]); end
    checks++; if (q1[3] !== 16'd0) begin errors++; $display("FAIL sat_7: got %0d want 0", q1[3]); end
    checks++; if (q1[4] !== 16'd1) begin errors++; $display("FAIL sat_15: got %0d want 1", q1[4]); end
    checks++; if (q1.size() !== 64) begin errors++; $display("FAIL sat_count: got %0d want 64", q1.size()); end
    checks++; if (done1 !== 1) begin errors++; $display("FAIL sat_done: got %0d want 1", done1); end
  endtask

  task automatic test_short_and_err();
    do_reset(1'b1); fill_ramp(1);
    send_frame(10, -1, -1); idle(80);
    checks++; if (q1.size() !== 64) begin errors++; $display("FAIL short_count: got %0d want 64", q1.size()); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (q1[i] !== ((i < 10) ? 16'(i + 1) : 16'd0)) begin errors++; $display("FAIL short_bin%0d: got %0d", i, q1[i]); end
    end
    checks++; if (done1 !== 1) begin errors++; $display("FAIL short_done: got %0d want 1", done1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL short_err: got %b want 0", err1); end
    fill_ramp(0);
    send_frame(64, 19, -1); idle(80);
    checks++; if (q1.size() !== 128) begin errors++; $display("FAIL err_count: got %0d want 128", q1.size()); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (q1[64 + i] !== ((i < 19) ? 16'(i) : 16'd0)) begin errors++; $display("FAIL err_bin%0d: got %0d", i, q1[64 + i]); end
    end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err1); end
    checks++; if (fw1 !== 16'd2) begin errors++; $display("FAIL err_written: got %0d want 2", fw1); end
  endtask

  task automatic test_single_beat();
    do_reset(1'b1);
    frame_dat[0] = 16'd80;
    send_frame(1, -1, -1); idle(80);
    checks++; if (q1.size() !== 64) begin errors++; $display("FAIL single_count: got %0d want 64", q1.size()); end
    checks++; if (q1[0] !== 16'd10) begin errors++; $display("FAIL single_bin0: got %0d want 10", q1[0]); end
    checks++; if ({q1[1], q1[63]} !== 32'd0) begin errors++; $display("FAIL single_pad: got %0d %0d want 0 0", q1[1], q1[63]); end
    checks++; if (done1 !== 1) begin errors++; $display("FAIL single_done: got %0d want 1", done1); end
  endtask

  task automatic test_overflow();
    do_reset(1'b1); fill_ramp(0);
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", ovf1); end
    fifo_full = 1'b1;
    send_frame(64, -1, -1); idle(80);
    fifo_full = 1'b0;
    checks++; if (q1.size() !== 64) begin errors++; $display("FAIL ovf_count: got %0d want 64", q1.size()); end
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf1); end
    checks++; if (fw1 !== 16'd1) begin errors++; $display("FAIL ovf_written: got %0d want 1", fw1); end
  endtask

  task automatic test_enable();
    do_reset(1'b0); fill_ramp(0);
    send_frame(70, -1, -1); idle(80);
    checks++; if (q1.size() !== 0) begin errors++; $display("FAIL en_off_count: got %0d want 0", q1.size()); end
    checks++; if ({fw1, fdr1} !== 32'd0) begin errors++; $display("FAIL en_off_counts: got %0d %0d want 0 0", fw1, fdr1); end
    enable = 1'b1; idle(2);
    send_frame(128, -1, 30); idle(80);
    send_frame(70, -1, -1); idle(80);
    checks++; if (q1.size() !== 64) begin errors++; $display("FAIL en_mid_count: got %0d want 64", q1.size()); end
    checks++; if (fw1 !== 16'd1) begin errors++; $display("FAIL en_mid_written: got %0d want 1", fw1); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1); fill_ramp(0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_50m);
      fft_valid = 1'b1; fft_sop = (i == 0); fft_eop = 1'b0; fft_data = frame_dat[i];
    end
    @(posedge clk_50m); #2;
    checks++; if (bus1.fifo_wr_req !== 1'b1) begin errors++; $display("FAIL arst_pre_req: got %b want 1", bus1.fifo_wr_req); end
    rst_n = 1'b0; #1;
    checks++; if (bus1.fifo_wr_req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b want 0", bus1.fifo_wr_req); end
    checks++; if (bus1.fifo_wr_data !== 16'd0) begin errors++; $display("FAIL arst_data: got %0d want 0", bus1.fifo_wr_data); end
    fft_valid = 1'b0; fft_sop = 1'b0;
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50m);
    q1.delete(); done1 = 0;
    send_frame(128, -1, -1); idle(80);
    checks++; if (q1.size() !== 64) begin errors++; $display("FAIL arst_next_count: got %0d want 64", q1.size()); end
    checks++; if ({q1[0], q1[5], q1[63]} !== {16'd0, 16'd5, 16'd63}) begin errors++; $display("FAIL arst_next_data: got %0d %0d %0d want 0 5 63", q1[0], q1[5], q1[63]); end
    checks++; if (fw1 !== 16'd1) begin errors++; $display("FAIL arst_next_written: got %0d want 1", fw1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decim();
    test_room();
    test_saturate();
    test_short_and_err();
    test_single_beat();
    test_overflow();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spectrum_wr_sched.md
Name: spectrum_wr_sched

Overview:
- Write-side scheduler between the FFT magnitude stream and the dual-clock spectrum FIFO that feeds the LCD bar renderer.
- Captures the first NUM_BINS bins of selected FFT frames and decimates the frame rate to 1 of every DECIM frames.
- Admits a frame only when the FIFO has room for a whole frame, so the display never receives a partial spectrum.
- Scales and saturates each bin into a bar length, pads short frames with zeros, and keeps drop, overflow and error status.

Parameters:
- NUM_BINS, 64, words written per captured frame (bars on screen)
- DECIM, 4, one frame captured per DECIM frames started; 1 means every frame
- FIFO_DEPTH, 256, FIFO capacity in words
- SCALE_SHIFT, 3, right shift applied to fft_data
- MAX_LEVEL, 16'd400, saturation ceiling after the shift

Ports:
- clk_50m  in  1  system clock; the FFT side and the FIFO write port are both in this domain
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable; sampled only at frame boundaries
- fft_data  in  16  unsigned bin magnitude
- fft_sop  in  1  first bin of a frame; qualified by fft_valid
- fft_eop  in  1  last bin of a frame; qualified by fft_valid
- fft_valid  in  1  beat valid
- fifo_wrusedw  in  8  FIFO write-side fill level (log2 FIFO_DEPTH)
- fifo_full  in  1  FIFO full
- fifo_wr_req  out  1  FIFO write strobe
- fifo_wr_data  out  16  scaled bar length
- frame_wr_done  out  1  one-cycle pulse after the last word of a frame is written
- frames_written  out  16  wrapping count of completed frames
- frames_dropped  out  16  wrapping count of frames skipped for lack of FIFO room
- ovf_sticky  out  1  set when a write is attempted while fifo_full is high
- err_sticky  out  1  set on a protocol error (sop arrives mid-frame)

Behaviour:
- Reset: state IDLE; all outputs 0; decim_cnt = 0; bin_cnt = 0. Sticky flags clear only on reset.
- A beat is accepted only when fft_valid = 1. fft_sop and fft_eop are ignored when fft_valid = 0.
- Scaling: s = fft_data >> SCALE_SHIFT. Output word = (s > MAX_LEVEL) ? MAX_LEVEL : s. Computed combinationally, then registered.
- Write latency: fifo_wr_req and fifo_wr_data are registered 1 cycle after the accepted beat. At most one word is written per cycle.
- States:
  - IDLE: if enable = 1, go to ARM.
  - ARM:
    - If enable = 0, go to IDLE.
    - On an sop beat, do the admission check. Admitted if decim_cnt == 0 and fifo_wrusedw <= FIFO_DEPTH - NUM_BINS.
    - Admitted: write the sop beat as bin 0; bin_cnt = 1; go to CAPTURE.
    - decim_cnt == 0 but no FIFO room: frames_dropped += 1; go to SKIP.
    - decim_cnt != 0: go to SKIP without counting a drop.
    - decim_cnt increments modulo DECIM on every sop beat seen in ARM.
  - CAPTURE:
    - Each valid beat is written as bin bin_cnt, then bin_cnt increments.
    - On writing bin NUM_BINS-1: if that beat has eop, go to ARM; otherwise go to DRAIN.
    - eop beat with bin_cnt < NUM_BINS-1 (short frame): write that bin, then go to PAD.
    - sop beat in CAPTURE (protocol error): set err_sticky, do not write that beat, go to PAD. The interrupting frame is not captured.
  - PAD: write 16'd0 on each cycle, ignoring the stream, until bin NUM_BINS-1 is written; then go to ARM.
  - DRAIN: discard beats until an eop beat, then go to ARM. An sop beat here sets err_sticky and is treated as the start of a skipped frame; stay in DRAIN.
  - SKIP: discard beats until an eop beat, then go to ARM. An sop beat here sets err_sticky; stay in SKIP.
- frame_wr_done pulses in the cycle after the write of bin NUM_BINS-1, and frames_written increments in the same cycle. Both counters wrap 16'hFFFF -> 0.
- Frame size: every captured frame produces exactly NUM_BINS writes, including padded ones.
- Overflow: if fifo_full = 1 in a write cycle, fifo_wr_req is still driven and ovf_sticky is set. The FIFO discards the word. The word count does not change.
- enable deasserted in CAPTURE, PAD or DRAIN: the current frame completes; the change takes effect in ARM.
- Asynchronous reset mid-frame: the partial frame is abandoned. The FIFO is cleared by the same reset through aclr.
- Single-beat frame (sop and eop together): handled as a short frame; bin 0 is data and bins 1..NUM_BINS-1 are zeros.

Test Plan:
- DECIM=1, FIFO empty, 128-beat frame with fft_data = index*8 -> 64 writes of 0..63, frame_wr_done once, frames_written = 1.
- DECIM=4, 8 back-to-back frames -> frames 0 and 4 captured, 128 writes total, frames_dropped = 0.
- fifo_wrusedw = 193 at sop, DECIM=1 -> frame skipped, frames_dropped = 1, no writes; next sop with fifo_wrusedw = 192 -> captured.
- fft_data = 16'hFFFF -> written value 400. fft_data = 16'd3199 -> 399. fft_data = 16'd3200 -> 400.
- eop on the 10th beat -> 10 data words, then 54 zeros, frame_wr_done asserted; sop on the 20th beat of the next frame -> err_sticky = 1 and exactly 64 words written for that frame.
- Assert rst_n low mid-CAPTURE -> all outputs 0 within the same cycle; the next complete frame after release is captured normally.
